ramb4_s2_port_arb: RTL and testbench
====================================

// Module: ramb4_s2_port_arb
// PURPOSE
//  Two-requester round-robin arbiter sharing port A of a 2048x2 dual-port block RAM (ramb4_s2_s2_int class).
//  Muxes requester address/data/write-enable onto the RAM port and returns read data with a tagged valid strobe.
//  Optionally zero-fills the whole array after reset before any requester is served.
//  Sits between two client engines and the RAM; port B of the RAM is untouched.
// PARAMETERS
//  ADDR_W     11     RAM address width (depth = 2**ADDR_W)
//  DATA_W     2      RAM data width
//  PRIO_INIT  0      requester that wins the first contended cycle after reset (0 or 1)
//  CLR_VALUE  2'b00  word written during clear sweep (used only with RAMB4_ARB_CLEAR_EN)
// PORTS
//  CLKA      in   1       clock; RAM port A shares this clock
//  RSTB      in   1       synchronous, active-high reset
//  req0      in   1       requester 0 access request; held until gnt0
//  we0       in   1       requester 0 write (1) / read (0)
//  addr0     in   ADDR_W  requester 0 address
//  din0      in   DATA_W  requester 0 write data
//  gnt0      out  1       requester 0 access accepted this cycle
//  rvalid0   out  1       requester 0 read data valid
//  req1/we1/addr1/din1/gnt1/rvalid1  as above for requester 1
//  rdata     out  DATA_W  read data, shared; qualified by rvalid0/rvalid1
//  busy      out  1       clear sweep in progress; no grants
//  ram_en    out  1       to RAM ENA
//  ram_we    out  1       to RAM WEA
//  ram_rst   out  1       to RAM RSTA; tied 0
//  ram_addr  out  ADDR_W  to RAM ADDRA
//  ram_di    out  DATA_W  to RAM DIA
//  ram_do    in   DATA_W  from RAM DOA (registered in RAM, 1-cycle latency)
// BEHAVIOUR
//  - Reset (RSTB=1 at CLKA edge): rvalid0/1=0, gnt0/1=0, ram_en=0, ram_we=0; last-grant pointer = ~PRIO_INIT;
//    state = CLEAR (macro defined) else SERVE. Outstanding read dropped, its rvalid never asserted.
//  - States: CLEAR -> SERVE when clear counter reaches 2**ADDR_W-1; SERVE is terminal until reset.
//  - SERVE grant (combinational, same cycle as req): only one req -> grant it; both -> grant the requester
//    that is NOT the last-grant pointer; none -> ram_en=0. At most one gnt per cycle.
//  - Pointer updates at edge only when a grant issues; idle cycles do not move it.
//  - Granted requester's we/addr/din drive ram_we/ram_addr/ram_di combinationally; ram_en=1.
//  - Read grant in cycle N -> rvalidX=1 for exactly cycle N+1, rdata=ram_do. Write grant: no rvalid.
//  - Back-to-back reads accepted every cycle (full throughput); rvalid sequence mirrors grant order.
//  - Same-address write by one requester and read by the other in consecutive cycles: read sees new data.
//  - gnt is an accept strobe; requester may change addr/we/din or drop req the cycle after gnt.
//  - ram_rst constant 0; rdata when no rvalid is don't-care (raw ram_do).
// CONFIGURATION
//  RAMB4_ARB_CLEAR_EN defined: after reset, CLEAR state writes CLR_VALUE to addresses 0..2**ADDR_W-1,
//    one per cycle (ram_en=1, ram_we=1, ram_addr=counter), busy=1, gnt0/1=0; first grant possible in
//    cycle 2**ADDR_W after reset release (2048 cycles at default). RSTB mid-sweep restarts at address 0.
//  Not defined: no counter/CLEAR state; busy tied 0; grants possible first cycle after reset release;
//    RAM contents are whatever the RAM INIT parameters give.
// TESTING
//  - req0 only, read addr 0x005 (RAM INIT word 2'b10) -> gnt0 same cycle, rvalid0 next cycle, rdata=2'b10.
//  - req0 & req1 both held reads, PRIO_INIT=0 -> grants alternate 0,1,0,1; each rvalid one cycle after its gnt.
//  - req1 write 0x7FF<=2'b11, next cycle req0 read 0x7FF -> rvalid0 with rdata=2'b11; no rvalid1 ever.
//  - Read granted, RSTB pulsed next edge -> rvalid0 stays 0; next contended cycle grants PRIO_INIT first.
//  - RAMB4_ARB_CLEAR_EN, CLR_VALUE=2'b01, req0 held from reset -> busy=1 and no gnt for 2048 cycles,
//    then gnt0; read of 0x3A4 returns 2'b01.
//  - RAMB4_ARB_CLEAR_EN, RSTB asserted at sweep address 0x100 -> sweep restarts at 0x000, busy=1 2048 more cycles.

Source files
------------

// File: rtl/ramb4_s2_port_arb.sv
// Round-robin arbiter for two requesters sharing port A of a 2048x2 block RAM.
// Define RAMB4_ARB_CLEAR_EN to zero-fill (CLR_VALUE) the whole array after reset.
module ramb4_s2_port_arb #(
  parameter int                ADDR_W    = 11,
  parameter int                DATA_W    = 2,
  parameter bit                PRIO_INIT = 1'b0,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic              CLKA,
  input  logic              RSTB,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] din0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] din1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic              ram_rst,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do
);

  logic last_gnt_reg, last_gnt_next;
  logic rvalid0_reg, rvalid1_reg;
  logic serve;

`ifdef RAMB4_ARB_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_SERVE} state_t;
  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;

  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    if (state_reg == ST_CLEAR) begin
      clr_cnt_next = clr_cnt_reg + 1'b1;
      if (&clr_cnt_reg)
        state_next = ST_SERVE;
    end
  end

  assign serve = (state_reg == ST_SERVE);
`else
  assign serve = 1'b1;
`endif

  // Contended cycle goes to whoever did not win last; lone requests win outright.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (serve) begin
      if (req0 && req1) begin
        if (last_gnt_reg)
          gnt0 = 1'b1;
        else
          gnt1 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    ram_en        = gnt0 | gnt1;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_di        = CLR_VALUE;
    last_gnt_next = last_gnt_reg;
    if (gnt1) begin
      ram_we        = we1;
      ram_addr      = addr1;
      ram_di        = din1;
      last_gnt_next = 1'b1;
    end else if (gnt0) begin
      ram_we        = we0;
      ram_addr      = addr0;
      ram_di        = din0;
      last_gnt_next = 1'b0;
    end
`ifdef RAMB4_ARB_CLEAR_EN
    if (!serve) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = clr_cnt_reg;
      ram_di   = CLR_VALUE;
    end
`endif
  end

  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      last_gnt_reg <= ~PRIO_INIT;
      rvalid0_reg  <= 1'b0;
      rvalid1_reg  <= 1'b0;
    end else begin
      last_gnt_reg <= last_gnt_next;
      rvalid0_reg  <= gnt0 & ~we0;
      rvalid1_reg  <= gnt1 & ~we1;
    end
  end

  assign rvalid0 = rvalid0_reg;
  assign rvalid1 = rvalid1_reg;
  assign rdata   = ram_do;
  assign busy    = ~serve;
  assign ram_rst = 1'b0;

endmodule

// File: tb/tb_ramb4_s2_port_arb.sv
// Randomized bench for ramb4_s2_port_arb with a behavioural RAM and a spec-level reference model.
// Clear-sweep checks are included when RAMB4_ARB_CLEAR_EN is defined.
module tb_ramb4_s2_port_arb;
  localparam int         AW    = 11;
  localparam int         DEPTH = 2048;
  localparam logic [1:0] CLRV  = 2'b01;
  localparam bit         PRIO  = 1'b0;
`ifdef RAMB4_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          CLKA = 1'b0;
  logic          RSTB;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [1:0]    din0, din1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [1:0]    rdata;
  logic          ram_en, ram_we, ram_rst;
  logic [AW-1:0] ram_addr;
  logic [1:0]    ram_di, ram_do;

  ramb4_s2_port_arb #(.ADDR_W(AW), .DATA_W(2), .PRIO_INIT(PRIO), .CLR_VALUE(CLRV)) dut (
    .CLKA(CLKA), .RSTB(RSTB),
    .req0(req0), .we0(we0), .addr0(addr0), .din0(din0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .din1(din1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_rst(ram_rst),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
  );

  always #5 CLKA = ~CLKA;

  // Behavioural 2048x2 RAM port A, registered output, write-first.
  logic [1:0] ram_mem [0:DEPTH-1];
  logic [1:0] ram_q;
  always @(posedge CLKA) begin
    if (ram_en) begin
      if (ram_we) begin
        ram_mem[ram_addr] <= ram_di;
        ram_q             <= ram_di;
      end else begin
        ram_q <= ram_mem[ram_addr];
      end
    end
  end
  assign ram_do = ram_q;

  // Reference model state
  logic [1:0] mdl [0:DEPTH-1];
  bit         m_last;
  bit         pv0, pv1;
  logic [1:0] pdata;
  int         clear_left;
  int         win;
  bit         started;
  bit         dut_g0;
  bit         dut_busy;
  int         checks;
  int         failures;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check DUT outputs at negedge against the model, then advance the model.
  task automatic cycle();
    int         w;
    logic       s_we;
    logic [AW-1:0] s_addr;
    logic [1:0] s_din;
    w = -1;
    s_we = 1'b0;
    s_addr = '0;
    s_din = '0;
    @(negedge CLKA);
    dut_g0   = gnt0;
    dut_busy = busy;
    if (started) begin
      chk("rvalid0", 32'(rvalid0), 32'(pv0));
      chk("rvalid1", 32'(rvalid1), 32'(pv1));
      if (pv0 || pv1) chk("rdata", 32'(rdata), 32'(pdata));
      chk("ram_rst", 32'(ram_rst), 32'd0);
    end
    if (!RSTB) begin
      if (clear_left > 0) begin
        chk("busy_clr", 32'(busy), 32'd1);
        chk("gnt0_clr", 32'(gnt0), 32'd0);
        chk("gnt1_clr", 32'(gnt1), 32'd0);
        chk("ram_en_clr", 32'(ram_en), 32'd1);
        chk("ram_we_clr", 32'(ram_we), 32'd1);
        chk("ram_addr_clr", 32'(ram_addr), 32'(DEPTH - clear_left));
        chk("ram_di_clr", 32'(ram_di), 32'(CLRV));
      end else begin
        if (req0 && req1) w = (m_last == 1'b0) ? 1 : 0;
        else if (req0)    w = 0;
        else if (req1)    w = 1;
        if (w == 0) begin s_we = we0; s_addr = addr0; s_din = din0; end
        if (w == 1) begin s_we = we1; s_addr = addr1; s_din = din1; end
        chk("busy", 32'(busy), 32'd0);
        chk("gnt0", 32'(gnt0), 32'(w == 0));
        chk("gnt1", 32'(gnt1), 32'(w == 1));
        chk("ram_en", 32'(ram_en), 32'(w >= 0));
        if (w >= 0) begin
          chk("ram_we", 32'(ram_we), 32'(s_we));
          chk("ram_addr", 32'(ram_addr), 32'(s_addr));
          if (s_we) chk("ram_di", 32'(ram_di), 32'(s_din));
        end
      end
    end
    pv0 = 1'b0;
    pv1 = 1'b0;
    if (RSTB) begin
      m_last     = ~PRIO;
      clear_left = CLR_EN ? DEPTH : 0;
      started    = 1'b1;
    end else if (clear_left > 0) begin
      mdl[DEPTH - clear_left] = CLRV;
      clear_left--;
    end else if (w >= 0) begin
      m_last = w[0];
      if (s_we) begin
        mdl[s_addr] = s_din;
      end else begin
        pdata = mdl[s_addr];
        if (w == 0) pv0 = 1'b1; else pv1 = 1'b1;
      end
    end
    win = w;
    @(posedge CLKA);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit p0, p1;
    checks = 0; failures = 0; started = 1'b0;
    pv0 = 1'b0; pv1 = 1'b0; pdata = '0; clear_left = 0; win = -1; m_last = ~PRIO;
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = 2'($urandom_range(0, 3));
      mdl[i]     = ram_mem[i];
    end
    ram_mem[5] = 2'b10;
    mdl[5]     = 2'b10;
    RSTB = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; din0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; din1 = '0;
    repeat (3) cycle();
    RSTB = 1'b0;

    // Lone read of 0x005 held from reset release; first grant latency depends on the sweep.
    req0 = 1; we0 = 0; addr0 = 11'h005;
    n = 0;
    for (int i = 0; i < DEPTH + 20; i++) begin
      cycle();
      if (dut_g0) break;
      n++;
    end
    chk("first_grant_cycle", 32'(n), 32'(CLR_EN ? DEPTH : 0));
    addr0 = 11'h3A4;
    cycle();
    req0 = 0;
    cycle();

    // Both requesters streaming reads: alternating grants, full throughput.
    req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    for (int i = 0; i < 8; i++) begin
      addr0 = 11'($urandom_range(0, DEPTH - 1));
      addr1 = 11'($urandom_range(0, DEPTH - 1));
      cycle();
    end
    req0 = 0; req1 = 0;
    cycle();

    // Write by requester 1 then read of the same address by requester 0.
    req1 = 1; we1 = 1; addr1 = 11'h7FF; din1 = 2'b11;
    cycle();
    req1 = 0; we1 = 0;
    req0 = 1; we0 = 0; addr0 = 11'h7FF;
    cycle();
    req0 = 0;
    cycle();

    // Random traffic; a request is held unchanged until granted.
    p0 = 0; p1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0) begin
        req0 = ($urandom_range(0, 2) != 0); we0 = 1'($urandom_range(0, 1));
        addr0 = 11'($urandom_range(0, 7)); din0 = 2'($urandom_range(0, 3));
      end
      if (!p1) begin
        req1 = ($urandom_range(0, 2) != 0); we1 = 1'($urandom_range(0, 1));
        addr1 = 11'($urandom_range(0, 7)); din1 = 2'($urandom_range(0, 3));
      end
      cycle();
      p0 = req0 && (win != 0);
      p1 = req1 && (win != 1);
    end
    req0 = 0; req1 = 0;
    cycle();

    // Reset on the edge that would launch a read: its rvalid must never appear.
    req0 = 1; we0 = 0; addr0 = 11'h005; RSTB = 1'b1;
    cycle();
    req0 = 0; RSTB = 1'b0;
    cycle();
    for (int i = 0; i < DEPTH + 5 && clear_left > 0; i++) cycle();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 11'h010; addr1 = 11'h020;
    cycle();
    chk("prio_after_reset", 32'(dut_g0), 32'(PRIO == 1'b0));
    req0 = 0; req1 = 0;
    cycle();
    cycle();

`ifdef RAMB4_ARB_CLEAR_EN
    // Reset in the middle of a sweep restarts it from address 0.
    RSTB = 1'b1;
    cycle();
    RSTB = 1'b0;
    repeat (256) cycle();
    RSTB = 1'b1;
    cycle();
    RSTB = 1'b0;
    n = 0;
    for (int i = 0; i < DEPTH + 20; i++) begin
      cycle();
      if (!dut_busy) break;
      n++;
    end
    chk("busy_after_midsweep_reset", 32'(n), 32'(DEPTH));
    req0 = 1; we0 = 0; addr0 = 11'h3A4;
    cycle();
    req0 = 0;
    cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
